// File: rtl/filter_feeder.sv
// filter_feeder: buffers float32 samples in a FIFO, issues them one at a time to the Filter,
// and registers each result behind a valid/ready output with sticky overflow/timeout flags.
module filter_feeder #(
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_wr,
  output logic        in_full,
  output logic [31:0] f_x,
  output logic        f_start,
  input  logic        f_ready,
  input  logic        f_valid,
  input  logic [31:0] f_y,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] done_cnt,
  output logic        err_ovf,
  output logic        err_tmo
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic empty, push, go, cap, tmo;
  assign empty = wptr == rptr;
  assign in_full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign push = in_wr && !in_full;
  // never issue while a result is still pending downstream
  assign go = state == IDLE && !empty && f_ready && !out_valid;
  assign cap = state == WAIT && f_valid;
  assign tmo = state == WAIT && !f_valid && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = go ? ISSUE : state == ISSUE ? WAIT : (cap || tmo) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      f_x       <= '0;
      f_start   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done_cnt  <= '0;
      err_ovf   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= state == WAIT ? cnt + 1'b1 : '0;
      f_start   <= go;
      out_valid <= cap || (out_valid && !out_ready);
      if (push) wptr <= wptr + 1'b1;
      if (go) begin
        rptr <= rptr + 1'b1;
        f_x  <= mem[rptr[AW-1:0]];
      end
      if (cap) begin
        out_data <= f_y;
        done_cnt <= done_cnt + 16'd1;
      end
      if (in_wr && in_full) err_ovf <= 1'b1;
      if (tmo) err_tmo <= 1'b1;
    end
  end
endmodule

// File: tb/tb_filter_feeder.sv
// tb_filter_feeder: directed stimulus with a scoreboard monitor for filter_feeder.
module tb_filter_feeder;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] in_data = 0;
  logic        in_wr = 0;
  logic        in_full;
  logic [31:0] f_x;
  logic        f_start;
  logic        f_ready = 1;
  logic        f_valid;
  logic [31:0] f_y;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1;
  logic [15:0] done_cnt;
  logic        err_ovf, err_tmo;
  logic        model_en = 1;
  int checks = 0, errors = 0, hs = 0, cd = 0;
  logic [31:0] px;
  logic [31:0] exp_x[$], exp_y[$];

  filter_feeder #(.DEPTH(8), .AW(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_wr(in_wr), .in_full(in_full),
    .f_x(f_x), .f_start(f_start), .f_ready(f_ready), .f_valid(f_valid), .f_y(f_y),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done_cnt(done_cnt), .err_ovf(err_ovf), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] yfun(input logic [31:0] x);
    return x == 32'h3fc9a48e ? 32'h3f800000 : {x[15:0], x[31:16]} ^ 32'h5a5a0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  // Filter model: answers 5 cycles after seeing start
  always @(posedge clk) begin
    if (rst) begin
      cd <= 0;
      f_valid <= 1'b0;
      f_y <= '0;
    end else begin
      f_valid <= 1'b0;
      if (f_start && model_en) begin
        cd <= 5;
        px <= f_x;
      end else if (cd == 1) begin
        f_valid <= 1'b1;
        f_y <= yfun(px);
        cd <= 0;
      end else if (cd > 1) cd <= cd - 1;
    end
  end

  always @(negedge clk) begin
    if (rst) hs = 0;
    else begin
      if (f_start) begin
        chk("issue_expected", 32'(exp_x.size() != 0), 1);
        if (exp_x.size() != 0) chk("f_x", f_x, exp_x.pop_front());
      end
      if (out_valid && out_ready) begin
        hs++;
        chk("result_expected", 32'(exp_y.size() != 0), 1);
        if (exp_y.size() != 0) chk("out_data", out_data, exp_y.pop_front());
        chk("done_cnt_hs", 32'(done_cnt), 32'(hs));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input bit qx, input bit qy);
    in_wr = 1;
    in_data = d;
    cyc(1);
    in_wr = 0;
    if (qx) exp_x.push_back(d);
    if (qy) exp_y.push_back(yfun(d));
  endtask

  task automatic drain(input int lim);
    int i = 0;
    while (i < lim && (exp_x.size() != 0 || exp_y.size() != 0)) begin
      cyc(1);
      i++;
    end
    chk("drain", 32'(exp_x.size() + exp_y.size()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a;
    cyc(3);
    chk("rst_in_full", 32'(in_full), 0);
    chk("rst_f_start", 32'(f_start), 0);
    chk("rst_f_x", f_x, 0);
    chk("rst_out", {out_data[30:0], out_valid}, 0);
    chk("rst_done", 32'(done_cnt), 0);
    chk("rst_errs", {err_ovf, err_tmo}, 0);
    rst = 0;
    // single sample, first-sample latency of one cycle
    wr(32'h3fc9a48e, 1, 1);
    chk("lat_start0", 32'(f_start), 0);
    cyc(1);
    chk("lat_start1", 32'(f_start), 1);
    drain(100);
    chk("single_done", 32'(done_cnt), 1);
    // fill and overflow
    f_ready = 0;
    for (int i = 0; i < 8; i++) begin
      wr(32'h40000000 + i, 1, 1);
      if (i == 6) chk("full_at7", 32'(in_full), 0);
    end
    chk("full_at8", 32'(in_full), 1);
    chk("ovf_before", 32'(err_ovf), 0);
    wr(32'hdeadbeef, 0, 0);
    chk("ovf_after", 32'(err_ovf), 1);
    f_ready = 1;
    drain(400);
    chk("fill_done", 32'(done_cnt), 9);
    // backpressure
    out_ready = 0;
    a = 32'h41200000;
    wr(a, 1, 1);
    wr(32'h41a00000, 1, 1);
    n = 0;
    while (n < 50 && !out_valid) begin
      cyc(1);
      n++;
    end
    chk("bp_valid", 32'(out_valid), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (f_start || out_data !== yfun(a)) n++;
      cyc(1);
    end
    chk("bp_stall_events", n, 0);
    chk("bp_data", out_data, yfun(a));
    out_ready = 1;
    drain(100);
    // timeout
    model_en = 0;
    wr(32'hc0490fdb, 1, 0);
    wr(32'h3e800000, 1, 1);
    n = 0;
    while (n < 50 && !f_start) begin
      cyc(1);
      n++;
    end
    chk("tmo_issue", 32'(f_start), 1);
    cyc(16);
    chk("tmo_early", 32'(err_tmo), 0);
    cyc(1);
    chk("tmo_set", 32'(err_tmo), 1);
    chk("tmo_done", 32'(done_cnt), 11);
    model_en = 1;
    drain(100);
    chk("tmo_next_done", 32'(done_cnt), 12);
    // reset in the middle of WAIT
    model_en = 0;
    f_ready = 0;
    for (int i = 0; i < 4; i++) wr(32'h50000000 + i, 1, 0);
    f_ready = 1;
    n = 0;
    while (n < 50 && !f_start) begin
      cyc(1);
      n++;
    end
    cyc(3);
    rst = 1;
    exp_x.delete();
    exp_y.delete();
    cyc(1);
    rst = 0;
    chk("mrst_out", {in_full, f_start, out_valid, err_ovf, err_tmo}, 0);
    chk("mrst_vals", f_x | out_data | 32'(done_cnt), 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (f_start) n++;
      cyc(1);
    end
    chk("mrst_no_start", n, 0);
    model_en = 1;
    wr(32'h3f000000, 1, 1);
    drain(100);
    chk("mrst_done", 32'(done_cnt), 1);
    // simultaneous write and pop at occupancy 4
    f_ready = 0;
    for (int i = 0; i < 4; i++) wr(32'h60000000 + i, 1, 1);
    in_wr = 1;
    in_data = 32'h60000004;
    f_ready = 1;
    cyc(1);
    in_wr = 0;
    f_ready = 0;
    exp_x.push_back(32'h60000004);
    exp_y.push_back(yfun(32'h60000004));
    chk("sim_not_full", 32'(in_full), 0);
    for (int i = 5; i < 8; i++) wr(32'h60000000 + i, 1, 1);
    chk("sim_occ7", 32'(in_full), 0);
    wr(32'h60000008, 1, 1);
    chk("sim_occ8", 32'(in_full), 1);
    f_ready = 1;
    drain(400);
    chk("final_done", 32'(done_cnt), 10);
    chk("final_errs", {err_ovf, err_tmo}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/filter_feeder.md
# filter_feeder

Upstream sequencer for the `Filter` stage. It buffers IEEE-754 single-precision samples in a small FIFO and issues them one at a time to the `Filter` via its `start`/`ready` handshake. It captures each `y` result on `valid` and presents it downstream through a valid/ready register. It also detects overflow and a stalled `Filter`, keeping a sticky error flag for each.

## Interface

Parameters:
- `DEPTH`, 8: sample FIFO entries; power of two, at least 2.
- `AW`, 3: log2(`DEPTH`).
- `TIMEOUT`, 1024: maximum cycles allowed in WAIT before abort; at least 2.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_data`, in, 32: float32 sample to enqueue.
- `in_wr`, in, 1: enqueue strobe.
- `in_full`, out, 1: FIFO holds `DEPTH` entries.
- `f_x`, out, 32: sample to the `Filter` `x` input.
- `f_start`, out, 1: one-cycle start pulse to the `Filter`.
- `f_ready`, in, 1: `Filter` idle and able to accept `start`.
- `f_valid`, in, 1: `Filter` result strobe.
- `f_y`, in, 32: `Filter` result.
- `out_data`, out, 32: captured result.
- `out_valid`, out, 1: `out_data` holds an unconsumed result.
- `out_ready`, in, 1: downstream accepts `out_data`.
- `done_cnt`, out, 16: number of results captured; wraps at 0xFFFF to 0.
- `err_ovf`, out, 1: sticky; set when a write arrives while full.
- `err_tmo`, out, 1: sticky; set on a WAIT timeout.

## Operation

- Reset values: `in_full`=0, `f_x`=0, `f_start`=0, `out_data`=0, `out_valid`=0, `done_cnt`=0, `err_ovf`=0, `err_tmo`=0. The FIFO is emptied, the FSM goes to IDLE and the timeout counter is cleared.
- **FIFO:**
  - Registered read/write pointers with `AW+1` bits each.
  - Full when the pointers differ only in the MSB; empty when they are equal. Pointers wrap modulo 2·`DEPTH`.
  - A write while `in_full`=1 is dropped and sets `err_ovf`. This holds even if a pop occurs in the same cycle, because full is evaluated on pre-edge state.
  - Simultaneous write and pop when not full: both take effect and the occupancy is unchanged.
- **FSM states: IDLE, ISSUE, WAIT.**
  - IDLE → ISSUE when FIFO non-empty, `f_ready`=1 and `out_valid`=0. On this edge `f_x` is loaded with the FIFO head, the FIFO pops and `f_start` is registered to 1.
  - ISSUE lasts one cycle, with `f_start`=1. ISSUE → WAIT unconditionally; `f_start` returns to 0.
  - WAIT → IDLE on `f_valid`=1. On that edge:
    - `out_data` is loaded with `f_y`.
    - `out_valid` is set to 1.
    - `done_cnt` increments.
  - WAIT → IDLE after `TIMEOUT` cycles in WAIT without `f_valid`. `err_tmo` is set, the sample is discarded, and `out_valid` and `done_cnt` are unchanged.
  - `f_valid` in the same cycle as the timeout takes priority: the result is captured and no error is flagged.
  - `f_valid` outside WAIT is ignored.
- `f_x` is held stable from ISSUE until the next IDLE→ISSUE transition.
- Output register:
  - `out_valid` clears on a cycle where `out_valid`=1 and `out_ready`=1.
  - The FSM never issues while `out_valid`=1, so an unconsumed result can never be overwritten.
- Sticky flags clear only on `rst`.
- A `rst` asserted mid-WAIT aborts the sample with no error flag. `f_start` is 0 on the cycle after `rst`.
- Data is passed bit-exact; no float arithmetic is performed.

## Timing

- `in_wr` at edge N: the entry is visible at N+1. If the FSM is idle and all conditions hold, `f_start` is high during cycle N+1..N+2, so first-sample latency to `f_start` is 1 cycle.
- `f_valid` sampled at edge M: `out_valid`=1 from M onward. The earliest next `f_start` is the cycle after `out_valid` drops.
- Back-to-back throughput: one sample per (`Filter` latency + 3) cycles when `out_ready` is tied to 1.
- Timeout counter:
  - Starts at 0 on entry to WAIT and increments every WAIT cycle.
  - Abort occurs at the edge where the count reaches `TIMEOUT`-1.

## Test plan

- Reset then single sample: write `in_data`=32'h3fc9a48e with `f_ready`=1. Expect one `f_start` pulse with `f_x`=32'h3fc9a48e. A bench model returns `f_y`=32'h3f800000 after 5 cycles; expect `out_data`=32'h3f800000, `out_valid`=1 and `done_cnt`=1.
- Fill: 9 writes with `f_ready`=0 and `DEPTH`=8. Expect `in_full`=1 after the 8th write and `err_ovf`=1 after the 9th. Releasing `f_ready` then yields exactly 8 issues in write order.
- Backpressure: hold `out_ready`=0 after the first result. Expect no second `f_start` until `out_ready`=1 for one cycle, and `out_data` unchanged throughout.
- Timeout: with `TIMEOUT`=16, never assert `f_valid`. Expect `err_tmo`=1 exactly 16 cycles after ISSUE, and the next queued sample issued afterward with `done_cnt` unchanged.
- Mid-operation reset: assert `rst` during WAIT with 3 entries queued. Expect all outputs at reset values, `in_full`=0, and no `f_start` until a new write arrives.
- Simultaneous write and pop at occupancy 4: occupancy stays 4, and the popped entry is the oldest one.
